// File: rtl/shock_pulse_driver.sv
// Shock actuator PWM driver: turns the upstream shock window into a PWM burst
// with a latched intensity, an enable gate, a hard burst-length limit and a
// fixed cooldown. Also keeps a saturating burst counter and a sticky timeout flag.
module shock_pulse_driver #(
    parameter int unsigned PERIOD_CYCLES    = 50000,
    parameter int unsigned COOLDOWN_CYCLES  = 25000000,
    parameter int unsigned MAX_BURST_CYCLES = 33554432
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_trigger,
    input  logic       i_enable,
    input  logic [1:0] i_level,
    input  logic       i_count_clr,
    output logic       o_shock_pin,
    output logic       o_busy,
    output logic [7:0] o_shock_count,
    output logic       o_fault
);

    localparam int unsigned    PW         = $clog2(PERIOD_CYCLES);
    localparam logic [PW-1:0]  QUARTER    = PW'(PERIOD_CYCLES / 4);
    localparam logic [PW-1:0]  PHASE_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [31:0]    BURST_LAST = 32'(MAX_BURST_CYCLES - 1);
    localparam logic [31:0]    COOL_LAST  = 32'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_COOLDOWN
    } state_t;

    state_t        state_r;
    state_t        state_nxt;
    logic          trig_prev_r;
    logic [PW-1:0] phase_r;
    logic [PW-1:0] high_r;
    logic [31:0]   burst_r;
    logic [31:0]   cool_r;
    logic [7:0]    count_r;
    logic          fault_r;

    logic rise;
    logic start;
    logic burst_limit;
    logic burst_exit;
    logic cool_done;

    // Decode the qualifying events used by both the FSM and the datapath.
    always_comb begin
        rise        = i_trigger & ~trig_prev_r;
        start       = (state_r == S_IDLE) && rise && i_enable;
        burst_limit = (state_r == S_BURST) && (burst_r == BURST_LAST);
        burst_exit  = (state_r == S_BURST) && (!i_trigger || !i_enable || (burst_r == BURST_LAST));
        cool_done   = (state_r == S_COOLDOWN) && (cool_r == COOL_LAST);
    end

    // Trigger history; also tracked while in reset so a trigger held across
    // reset release is not mistaken for a fresh rise.
    always_ff @(posedge i_clk) begin
        trig_prev_r <= i_trigger;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE:     if (start)      state_nxt = S_BURST;
            S_BURST:    if (burst_exit) state_nxt = S_COOLDOWN;
            S_COOLDOWN: if (cool_done)  state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        o_shock_pin   = (state_r == S_BURST) && (phase_r < high_r);
        o_busy        = (state_r != S_IDLE);
        o_shock_count = count_r;
        o_fault       = fault_r;
    end

    // PWM phase, burst length and cooldown counters plus latched intensity.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase_r <= '0;
            high_r  <= '0;
            burst_r <= '0;
            cool_r  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        high_r  <= QUARTER * PW'(i_level);
                        phase_r <= '0;
                        burst_r <= '0;
                    end
                end
                S_BURST: begin
                    if (burst_exit) begin
                        phase_r <= '0;
                        burst_r <= '0;
                        cool_r  <= '0;
                    end else begin
                        burst_r <= burst_r + 32'd1;
                        phase_r <= (phase_r == PHASE_LAST) ? '0 : phase_r + PW'(1);
                    end
                end
                S_COOLDOWN: begin
                    cool_r <= cool_done ? '0 : cool_r + 32'd1;
                end
                default: begin
                    cool_r <= '0;
                end
            endcase
        end
    end

    // Saturating burst counter and sticky timeout flag; a start or timeout in
    // the same cycle as a clear takes effect after the clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_r <= '0;
            fault_r <= 1'b0;
        end else begin
            if (start) begin
                if (i_count_clr) begin
                    count_r <= 8'd1;
                end else if (count_r != '1) begin
                    count_r <= count_r + 8'd1;
                end
            end else if (i_count_clr) begin
                count_r <= '0;
            end

            if (burst_limit) begin
                fault_r <= 1'b1;
            end else if (i_count_clr) begin
                fault_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shock_pulse_driver.sv
// Bench for shock_pulse_driver: directed scenarios with a cycle model built
// from burst age / remaining cooldown, compared every cycle, plus literal checks.
module tb_shock_pulse_driver;

    localparam int P = 8;
    localparam int C = 10;
    localparam int M = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic       en;
    logic [1:0] lvl;
    logic       clr;
    logic       pin;
    logic       busy;
    logic [7:0] count;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    // model state
    int m_age   = -1;  // cycles into current burst, -1 when no burst
    int m_cool  = 0;   // remaining cooldown cycles
    int m_high  = 0;
    int m_count = 0;
    int m_fault = 0;
    int m_prev  = 0;

    int busy_cnt = 0;
    int pin_cnt  = 0;

    shock_pulse_driver #(
        .PERIOD_CYCLES    (P),
        .COOLDOWN_CYCLES  (C),
        .MAX_BURST_CYCLES (M)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_trigger     (trig),
        .i_enable      (en),
        .i_level       (lvl),
        .i_count_clr   (clr),
        .o_shock_pin   (pin),
        .o_busy        (busy),
        .o_shock_count (count),
        .o_fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int rise;
        if (!rst_n) begin
            m_age = -1; m_cool = 0; m_count = 0; m_fault = 0; m_high = 0;
            m_prev = int'(trig);
            return;
        end
        rise   = (trig && m_prev == 0) ? 1 : 0;
        m_prev = int'(trig);
        if (clr) begin
            m_count = 0;
            m_fault = 0;
        end
        if (m_age >= 0) begin
            if (!trig || !en || m_age + 1 == M) begin
                if (m_age + 1 == M) m_fault = 1;
                m_age  = -1;
                m_cool = C;
            end else begin
                m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (rise == 1 && en) begin
            m_age   = 0;
            m_high  = (P / 4) * int'(lvl);
            m_count = (m_count < 255) ? m_count + 1 : 255;
        end
    endtask

    // One clock: model advances on the edge, outputs compared half a cycle later.
    task automatic cyc();
        int e_pin;
        int e_busy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        e_pin  = (m_age >= 0 && (m_age % P) < m_high) ? 1 : 0;
        e_busy = (m_age >= 0 || m_cool > 0) ? 1 : 0;
        chk("pin",   int'(pin),   e_pin);
        chk("busy",  int'(busy),  e_busy);
        chk("count", int'(count), m_count);
        chk("fault", int'(fault), m_fault);
        busy_cnt += int'(busy);
        pin_cnt  += int'(pin);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr_cnt();
        busy_cnt = 0;
        pin_cnt  = 0;
    endtask

    initial begin
        rst_n = 1'b0; trig = 1'b1; en = 1'b1; lvl = 2'd2; clr = 1'b0;

        // reset with trigger held high
        run(3);
        chk("rst_pin",   int'(pin),   0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_count", int'(count), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1'b1;
        run(5);
        chk("no_start_after_rst", int'(busy), 0);
        trig = 1'b0;
        run(2);

        // nominal 50 % burst, 20 cycles
        clr_cnt();
        trig = 1'b1;
        cyc();
        chk("start_latency_pin", int'(pin), 1);
        run(19);
        trig = 1'b0;
        run(15);
        chk("nom_busy_cycles", busy_cnt, 30);
        chk("nom_pin_cycles",  pin_cnt,  12);
        chk("nom_count",       int'(count), 1);
        chk("nom_fault",       int'(fault), 0);

        // timeout with trigger held for 60 cycles
        clr_cnt();
        trig = 1'b1;
        run(60);
        chk("to_busy_cycles", busy_cnt, 50);
        chk("to_pin_cycles",  pin_cnt,  20);
        chk("to_fault",       int'(fault), 1);
        chk("to_count",       int'(count), 2);
        chk("to_no_restart",  int'(busy),  0);
        trig = 1'b0;
        cyc();
        trig = 1'b1;
        cyc();
        chk("fresh_rise_busy",  int'(busy),  1);
        chk("fresh_rise_count", int'(count), 3);
        trig = 1'b0;

        // retrigger attempts during cooldown
        run(3);
        clr_cnt();
        trig = 1'b1; run(2);
        trig = 1'b0; run(1);
        trig = 1'b1; run(1);
        trig = 1'b0; run(10);
        chk("cool_retrig_count", int'(count), 3);
        chk("cool_retrig_pin",   pin_cnt, 0);

        // clear in idle
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr_count", int'(count), 0);
        chk("clr_fault", int'(fault), 0);

        // rise while disabled
        en = 1'b0; trig = 1'b1;
        run(3);
        chk("dis_busy",  int'(busy),  0);
        chk("dis_count", int'(count), 0);
        trig = 1'b0; en = 1'b1;
        cyc();

        // enable dropped 5 cycles into a burst
        trig = 1'b1;
        run(5);
        en = 1'b0;
        cyc();
        chk("en_drop_pin",  int'(pin),  0);
        chk("en_drop_busy", int'(busy), 1);
        run(9);
        chk("en_cool_last", int'(busy), 1);
        cyc();
        chk("en_cool_done", int'(busy), 0);
        trig = 1'b0; en = 1'b1;
        cyc();
        chk("en_count", int'(count), 1);

        // level 0 burst
        clr_cnt();
        lvl = 2'd0; trig = 1'b1;
        run(8);
        trig = 1'b0;
        run(12);
        chk("lvl0_pin_cycles", pin_cnt, 0);
        chk("lvl0_count", int'(count), 2);

        // level 3 latched, changed mid-burst
        clr_cnt();
        lvl = 2'd3; trig = 1'b1;
        cyc();
        lvl = 2'd1;
        run(15);
        trig = 1'b0;
        run(12);
        chk("lvl3_pin_cycles", pin_cnt, 12);

        // clear coincident with burst start
        trig = 1'b1; clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_start_count", int'(count), 1);
        trig = 1'b0;
        run(12);

        // clear coincident with timeout: set wins for fault
        trig = 1'b1;
        run(40);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_to_fault", int'(fault), 1);
        chk("clr_to_count", int'(count), 0);
        trig = 1'b0;
        run(12);

        // saturation over 256 back-to-back bursts
        clr = 1'b1; cyc(); clr = 1'b0;
        lvl = 2'd1;
        for (int b = 0; b < 256; b++) begin
            trig = 1'b1; cyc();
            trig = 1'b0; run(11);
        end
        chk("sat_count", int'(count), 255);
        chk("sat_fault", int'(fault), 0);

        // reset mid-burst
        lvl = 2'd2; trig = 1'b1;
        run(3);
        rst_n = 1'b0;
        cyc();
        chk("midrst_pin",   int'(pin),   0);
        chk("midrst_busy",  int'(busy),  0);
        chk("midrst_count", int'(count), 0);
        rst_n = 1'b1; trig = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
